// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Active-low one-hot column drive for column index idx.
  function automatic logic [NUM_COLS-1:0] col_onehot_n(input logic [IDX_W-1:0] idx);
    logic [NUM_COLS-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  // Index of the lowest-numbered row that is pulled low.
  function automatic logic [IDX_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a synchronous active-high reset to a fixed value.
module sync_2ff #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, row sampling, in-line press/release debounce.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 4,
  parameter int unsigned DEBOUNCE_TICKS = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_down,
  output logic                key_release
);

  localparam int unsigned      CNT_W     = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

  state_e              r_state, w_state;
  logic [IDX_W-1:0]    r_col, w_col;
  logic [IDX_W-1:0]    r_row, w_row;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [NUM_COLS-1:0] r_col_out;
  logic [3:0]          r_key_code, w_key_code;
  logic                r_key_valid, w_key_valid;
  logic                r_key_down, w_key_down;
  logic                r_key_release, w_key_release;
  logic [NUM_ROWS-1:0] w_row_s;
  logic                w_row_lvl;

  sync_2ff #(
    .WIDTH   (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .i_d (row_in),
    .o_q (w_row_s)
  );

  assign w_row_lvl = w_row_s[r_row];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SCAN;
      r_col         <= '0;
      r_row         <= '0;
      r_cnt         <= '0;
      r_col_out     <= col_onehot_n('0);
      r_key_code    <= '0;
      r_key_valid   <= 1'b0;
      r_key_down    <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_col         <= w_col;
      r_row         <= w_row;
      r_cnt         <= w_cnt;
      r_col_out     <= col_onehot_n(w_col);
      r_key_code    <= w_key_code;
      r_key_valid   <= w_key_valid;
      r_key_down    <= w_key_down;
      r_key_release <= w_key_release;
    end
  end

  // Next-state and next-output decode; the counter is shared and cleared on every state change.
  always_comb begin
    w_state       = r_state;
    w_col         = r_col;
    w_row         = r_row;
    w_cnt         = r_cnt;
    w_key_code    = r_key_code;
    w_key_valid   = 1'b0;
    w_key_down    = r_key_down;
    w_key_release = 1'b0;

    case (r_state)
      SCAN: begin
        if (r_cnt == SCAN_LAST) begin
          w_cnt = '0;
          if (w_row_s != '1) begin
            w_row   = lowest_low_row(w_row_s);
            w_state = DEBOUNCE;
          end else begin
            w_col = r_col + IDX_W'(1);
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      DEBOUNCE: begin
        if (w_row_lvl) begin
          w_cnt   = '0;
          w_state = SCAN;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt       = '0;
          w_key_code  = {r_row, r_col};
          w_key_valid = 1'b1;
          w_key_down  = 1'b1;
          w_state     = HOLD;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      HOLD: begin
        if (w_row_lvl) begin
          w_cnt   = '0;
          w_state = RELEASE;
        end
      end

      RELEASE: begin
        if (!w_row_lvl) begin
          w_cnt   = '0;
          w_state = HOLD;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt         = '0;
          w_key_down    = 1'b0;
          w_key_release = 1'b1;
          w_col         = r_col + IDX_W'(1);
          w_state       = SCAN;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_cnt   = '0;
        w_state = SCAN;
      end
    endcase
  end

  assign col_out     = r_col_out;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_down    = r_key_down;
  assign key_release = r_key_release;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural keypad matrix and a key-code scoreboard.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        key_release;

  logic [15:0] keys = '0;
  logic [3:0]  sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_valid  = 0;
  int          n_rel    = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_TICKS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .key_release (key_release)
  );

  // Pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot_n(input int idx);
    logic [3:0] e;
    e      = 4'hF;
    e[idx] = 1'b0;
    return e;
  endfunction

  // Returns just after the scanner switches onto column idx.
  task automatic wait_col(input int idx);
    logic [3:0] e;
    e = onehot_n(idx);
    for (int i = 0; i < 40 && col_out == e; i++) tick();
    for (int i = 0; i < 40 && col_out != e; i++) tick();
    check("wait_col", 32'(col_out), 32'(e));
  endtask

  // Scoreboard: every accepted press pops one expected code.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        n_valid++;
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) check("sb_key_code", 32'(key_code), 32'(sb_q.pop_front()));
      end
      if (key_release) n_rel++;
      if (key_valid || key_release)
        check("valid_release_exclusive", 32'(key_valid & key_release), 32'd0);
    end
  end

  initial begin
    int v0;
    int r0;
    int n;

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    check("rst_col_out", 32'(col_out), 32'hE);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_key_release", 32'(key_release), 32'h0);
    rst = 1'b0;

    // Idle scan: each column held exactly four cycles
    for (int k = 0; k < 40; k++) begin
      check("idle_scan_col", 32'(col_out), 32'(onehot_n((k / 4) % 4)));
      tick();
    end
    check("idle_no_valid", 32'(n_valid), 32'd0);

    // Clean press of row2/col1, held then released
    wait_col(1);
    v0 = n_valid;
    keys[9] = 1'b1;
    sb_q.push_back(4'd9);
    repeat (100) tick();
    check("press_valid_count", 32'(n_valid), 32'(v0 + 1));
    check("press_key_down", 32'(key_down), 32'd1);
    check("press_key_code", 32'(key_code), 32'd9);
    r0 = n_rel;
    keys[9] = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (key_release) begin
        n = i;
        break;
      end
    end
    check("release_latency", 32'(n), 32'd19);
    check("release_next_col", 32'(col_out), 32'hB);
    check("release_key_down", 32'(key_down), 32'd0);
    check("release_code_hold", 32'(key_code), 32'd9);
    tick();
    check("release_count", 32'(n_rel), 32'(r0 + 1));

    // Bouncing row0 on col3, then stable low
    wait_col(3);
    v0 = n_valid;
    sb_q.push_back(4'd3);
    for (int b = 0; b < 4; b++) begin
      keys[3] = 1'b1;
      repeat (5) tick();
      keys[3] = 1'b0;
      repeat (5) tick();
    end
    check("bounce_no_early_valid", 32'(n_valid), 32'(v0));
    keys[3] = 1'b1;
    n = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (key_valid) begin
        n = i;
        break;
      end
    end
    check("bounce_latency_min", 32'(n >= 19), 32'd1);
    check("bounce_key_code", 32'(key_code), 32'd3);
    repeat (30) tick();
    check("bounce_single_valid", 32'(n_valid), 32'(v0 + 1));
    r0 = n_rel;
    keys[3] = 1'b0;
    for (int i = 0; i < 60 && !key_release; i++) tick();
    check("bounce_release_seen", 32'(key_release), 32'd1);

    // Row3 glitch on col0 is rejected and scanning resumes on col0
    wait_col(0);
    v0 = n_valid;
    keys[12] = 1'b1;
    repeat (10) tick();
    keys[12] = 1'b0;
    repeat (6) tick();
    check("glitch_same_col", 32'(col_out), 32'hE);
    tick();
    check("glitch_then_next_col", 32'(col_out), 32'hD);
    repeat (60) tick();
    check("glitch_no_valid", 32'(n_valid), 32'(v0));
    check("glitch_code_hold", 32'(key_code), 32'd3);

    // Rows 1 and 3 on col2: lowest row wins; reset during HOLD
    wait_col(2);
    v0 = n_valid;
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    sb_q.push_back(4'd6);
    for (int i = 0; i < 60 && !key_valid; i++) tick();
    check("multi_valid_seen", 32'(key_valid), 32'd1);
    check("multi_key_code", 32'(key_code), 32'd6);
    repeat (3) tick();
    check("multi_hold_down", 32'(key_down), 32'd1);
    r0 = n_rel;
    rst  = 1'b1;
    keys = '0;
    tick();
    check("midrst_col_out", 32'(col_out), 32'hE);
    check("midrst_key_code", 32'(key_code), 32'h0);
    check("midrst_key_valid", 32'(key_valid), 32'h0);
    check("midrst_key_down", 32'(key_down), 32'h0);
    check("midrst_key_release", 32'(key_release), 32'h0);
    rst = 1'b0;
    repeat (60) tick();
    check("midrst_no_release", 32'(n_rel), 32'(r0));
    check("midrst_valid_count", 32'(n_valid), 32'(v0 + 1));
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
